// File: rtl/time_link_tx.sv
// BCD time-of-day keeper that serialises a 24-bit snapshot over a 3-wire link (wclk/din/lnk_reset).
// Define TIME_LINK_12H_EN for 12-hour mode (01..12, reset to 12:00:00); default is 24-hour.
module time_link_tx #(
  parameter int TICK_DIV = 25000000,
  parameter int BIT_DIV  = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_valid,
  input  logic [21:0] set_time,
  output logic        set_err,
  output logic [21:0] time_bcd,
  output logic        wclk,
  output logic        din,
  output logic        lnk_reset,
  output logic        busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(BIT_DIV + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] PHASE_MAX = HW'(BIT_DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RST_LO = 3'd1;
  localparam logic [2:0] S_RST_HI = 3'd2;
  localparam logic [2:0] S_BIT_LO = 3'd3;
  localparam logic [2:0] S_BIT_HI = 3'd4;

`ifdef TIME_LINK_12H_EN
  localparam logic [21:0] RESET_TIME = 22'h120000;
`else
  localparam logic [21:0] RESET_TIME = 22'h000000;
`endif

  logic [PW-1:0] presc_reg;
  logic [2:0]    state_reg;
  logic [HW-1:0] phase_reg;
  logic [4:0]    bit_idx_reg;
  logic [23:0]   shift_reg;
  logic          pending_reg;
  logic          rst_req_reg;

  logic          tick;
  logic          set_ok;
  logic          frame_req;
  logic          frame_start;
  logic          phase_done;
  logic [21:0]   time_inc;
  logic [2:0]    ones_bad;
  logic [1:0]    tens_bad;
  logic          hours_bad;

  // Ones digits sit at bit offsets 0/8/16, minute/second tens at 4/12.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ones
      assign ones_bad[gi] = set_time[gi*8 +: 4] > 4'd9;
    end
    for (gi = 0; gi < 2; gi++) begin : g_tens
      assign tens_bad[gi] = set_time[gi*8+4 +: 4] > 4'd5;
    end
  endgenerate

`ifdef TIME_LINK_12H_EN
  assign hours_bad = !(((set_time[21:20] == 2'd0) && (set_time[19:16] != 4'd0)) ||
                       ((set_time[21:20] == 2'd1) && (set_time[19:16] <= 4'd2)));
`else
  assign hours_bad = (set_time[21:20] == 2'd3) ||
                     ((set_time[21:20] == 2'd2) && (set_time[19:16] > 4'd3));
`endif

  assign set_ok      = set_valid && !((|ones_bad) || (|tens_bad) || hours_bad);
  assign tick        = (presc_reg == PRESC_MAX);
  assign frame_req   = tick || set_ok || rst_req_reg;
  assign frame_start = (state_reg == S_IDLE) && pending_reg;
  assign phase_done  = (phase_reg == PHASE_MAX);

  // Cascaded BCD increment of the current time.
  always_comb begin
    time_inc = time_bcd;
    if (time_bcd[3:0] != 4'd9) begin
      time_inc[3:0] = time_bcd[3:0] + 4'd1;
    end else begin
      time_inc[3:0] = 4'd0;
      if (time_bcd[7:4] != 4'd5) begin
        time_inc[7:4] = time_bcd[7:4] + 4'd1;
      end else begin
        time_inc[7:4] = 4'd0;
        if (time_bcd[11:8] != 4'd9) begin
          time_inc[11:8] = time_bcd[11:8] + 4'd1;
        end else begin
          time_inc[11:8] = 4'd0;
          if (time_bcd[15:12] != 4'd5) begin
            time_inc[15:12] = time_bcd[15:12] + 4'd1;
          end else begin
            time_inc[15:12] = 4'd0;
`ifdef TIME_LINK_12H_EN
            if (time_bcd[21:16] == 6'h12) begin
              time_inc[21:16] = 6'h01;
            end else if (time_bcd[19:16] == 4'd9) begin
`else
            if (time_bcd[21:16] == 6'h23) begin
              time_inc[21:16] = 6'h00;
            end else if (time_bcd[19:16] == 4'd9) begin
`endif
              time_inc[21:20] = time_bcd[21:20] + 2'd1;
              time_inc[19:16] = 4'd0;
            end else begin
              time_inc[19:16] = time_bcd[19:16] + 4'd1;
            end
          end
        end
      end
    end
  end

  // Timekeeping, set handling and the pending-frame flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      time_bcd    <= RESET_TIME;
      presc_reg   <= '0;
      set_err     <= 1'b0;
      pending_reg <= 1'b0;
      rst_req_reg <= 1'b1;
    end else begin
      set_err     <= set_valid && !set_ok;
      rst_req_reg <= 1'b0;
      if (set_ok) begin
        time_bcd  <= set_time;
        presc_reg <= '0;
      end else if (tick) begin
        time_bcd  <= time_inc;
        presc_reg <= '0;
      end else begin
        presc_reg <= presc_reg + PW'(1);
      end
      // A request landing in the start cycle survives as the next pending frame.
      pending_reg <= frame_req || (pending_reg && !frame_start);
    end
  end

  // Frame sequencer: reload clock pulse, then 24 data bits MSB-first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      phase_reg   <= '0;
      bit_idx_reg <= 5'd0;
      shift_reg   <= 24'd0;
      wclk        <= 1'b0;
      din         <= 1'b0;
      lnk_reset   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (pending_reg) begin
            state_reg   <= S_RST_LO;
            phase_reg   <= '0;
            bit_idx_reg <= 5'd23;
            shift_reg   <= {2'b00, time_bcd};
            busy        <= 1'b1;
            lnk_reset   <= 1'b1;
            wclk        <= 1'b0;
            din         <= 1'b0;
          end
        end
        S_RST_LO: begin
          if (phase_done) begin
            phase_reg <= '0;
            state_reg <= S_RST_HI;
            wclk      <= 1'b1;
          end else begin
            phase_reg <= phase_reg + HW'(1);
          end
        end
        S_RST_HI: begin
          if (phase_done) begin
            phase_reg <= '0;
            state_reg <= S_BIT_LO;
            wclk      <= 1'b0;
            lnk_reset <= 1'b0;
            din       <= shift_reg[23];
          end else begin
            phase_reg <= phase_reg + HW'(1);
          end
        end
        S_BIT_LO: begin
          if (phase_done) begin
            phase_reg <= '0;
            state_reg <= S_BIT_HI;
            wclk      <= 1'b1;
          end else begin
            phase_reg <= phase_reg + HW'(1);
          end
        end
        S_BIT_HI: begin
          if (phase_done) begin
            phase_reg <= '0;
            wclk      <= 1'b0;
            if (bit_idx_reg == 5'd0) begin
              state_reg <= S_IDLE;
              busy      <= 1'b0;
              din       <= 1'b0;
            end else begin
              state_reg   <= S_BIT_LO;
              shift_reg   <= {shift_reg[22:0], 1'b0};
              bit_idx_reg <= bit_idx_reg - 5'd1;
              // The bit that becomes the MSB after the shift.
              din         <= shift_reg[22];
            end
          end else begin
            phase_reg <= phase_reg + HW'(1);
          end
        end
        default: begin
          state_reg <= S_IDLE;
          phase_reg <= '0;
          wclk      <= 1'b0;
          din       <= 1'b0;
          lnk_reset <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_link_tx.sv
// Directed bench for time_link_tx with a wclk-driven receiver model and immediate-assertion checks.
module tb_time_link_tx;
  localparam int TICK_DIV = 1000;
  localparam int BIT_DIV  = 2;

`ifdef TIME_LINK_12H_EN
  localparam logic [21:0] RST_T    = 22'h120000;
  localparam logic [21:0] WRAP_SET = 22'h125959;
  localparam logic [21:0] WRAP_EXP = 22'h010000;
  localparam logic [21:0] BAD_H    = 22'h130000;
`else
  localparam logic [21:0] RST_T    = 22'h000000;
  localparam logic [21:0] WRAP_SET = 22'h235959;
  localparam logic [21:0] WRAP_EXP = 22'h000000;
  localparam logic [21:0] BAD_H    = 22'h240000;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set_valid = 1'b0;
  logic [21:0] set_time = 22'd0;
  logic        set_err;
  logic [21:0] time_bcd;
  logic        wclk;
  logic        din;
  logic        lnk_reset;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  time_link_tx #(.TICK_DIV(TICK_DIV), .BIT_DIV(BIT_DIV)) dut (
    .clk(clk), .reset(reset), .set_valid(set_valid), .set_time(set_time),
    .set_err(set_err), .time_bcd(time_bcd), .wclk(wclk), .din(din),
    .lnk_reset(lnk_reset), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: reload on a rise with lnk_reset high, then accept exactly 24 bits.
  logic [23:0] rx_q[$];
  logic [23:0] rx_sh = 24'd0;
  int rx_bits = 24;
  int rx_reloads = 0;
  int rx_extra = 0;
  always @(posedge wclk) begin
    if (lnk_reset) begin
      rx_bits = 0;
      rx_sh = 24'd0;
      rx_reloads++;
    end else if (rx_bits < 24) begin
      rx_sh = {rx_sh[22:0], din};
      rx_bits++;
      if (rx_bits == 24) rx_q.push_back(rx_sh);
    end else begin
      rx_extra++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_set(input logic [21:0] v);
    set_time = v;
    set_valid = 1'b1;
    @(negedge clk);
    set_valid = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int lim, input string tag);
    int k = 0;
    while (busy !== lvl && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, busy}, {31'd0, lvl});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r0, r1, prev, s0, s2, sz, hits;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_time", {10'd0, time_bcd}, {10'd0, RST_T});
    chk("rst_outs", {27'd0, wclk, din, lnk_reset, busy, set_err}, 32'd0);
    $display("step reset: time=%06h outs=%b", time_bcd, {wclk, din, lnk_reset, busy, set_err});

    // Reset release frame: latency, length and edge placement
    reset = 1'b0;
    @(negedge clk);
    chk("rel_busy_lat0", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("rel_busy_lat1", {31'd0, busy}, 32'd1);
    n = 0; r0 = -1; r1 = -1; prev = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (wclk === 1'b1 && prev == 0) begin
        if (r0 < 0) r0 = n;
        else if (r1 < 0) r1 = n;
      end
      prev = (wclk === 1'b1) ? 1 : 0;
      @(negedge clk);
    end
    chk("busy_len", n, 50 * BIT_DIV);
    chk("reload_rise", r0, BIT_DIV + 1);
    chk("first_data_rise", r1, 3 * BIT_DIV + 1);
    chk("frame0_count", rx_q.size(), 1);
    chk("frame0_data", {8'd0, rx_q[0]}, {10'd0, RST_T});
    chk("frame0_reloads", rx_reloads, 1);
    $display("step release: busy_len=%0d reload_rise=%0d data_rise=%0d data=%06h", n, r0, r1, rx_q[0]);

    // Set to the wrap value, then one tick
    do_set(WRAP_SET);
    s0 = cyc;
    chk("wrap_set_time", {10'd0, time_bcd}, {10'd0, WRAP_SET});
    chk("set_busy_lat0", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("set_busy_lat1", {31'd0, busy}, 32'd1);
    while (cyc < s0 + 999) @(negedge clk);
    chk("pre_tick_time", {10'd0, time_bcd}, {10'd0, WRAP_SET});
    @(negedge clk);
    chk("wrap_time", {10'd0, time_bcd}, {10'd0, WRAP_EXP});
    chk("frame1_count", rx_q.size(), 2);
    chk("frame1_data", {8'd0, rx_q[1]}, {10'd0, WRAP_SET});
    wait_busy(1'b1, 5, "tick_frame_start");
    wait_busy(1'b0, 120, "tick_frame_end");
    chk("frame2_count", rx_q.size(), 3);
    chk("frame2_data", {8'd0, rx_q[2]}, {10'd0, WRAP_EXP});
    $display("step wrap: time=%06h frames=%06h,%06h", time_bcd, rx_q[1], rx_q[2]);

    // Illegal sets: error pulse, time unchanged, no frame
    sz = rx_q.size();
    do_set(BAD_H);
    chk("bad_h_err", {31'd0, set_err}, 32'd1);
    chk("bad_h_time", {10'd0, time_bcd}, {10'd0, WRAP_EXP});
    @(negedge clk);
    chk("bad_h_err_clear", {31'd0, set_err}, 32'd0);
    hits = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy === 1'b1) hits++;
    end
    chk("bad_h_no_frame", hits, 0);
    do_set(22'h00005A);
    chk("bad_sones_err", {31'd0, set_err}, 32'd1);
    do_set(22'h006000);
    chk("bad_mtens_err", {31'd0, set_err}, 32'd1);
    chk("bad_time_kept", {10'd0, time_bcd}, {10'd0, WRAP_EXP});
    chk("bad_no_rx", rx_q.size(), sz);
    $display("step illegal: time=%06h frames=%0d", time_bcd, rx_q.size());

    // Set coinciding with a tick: set wins, prescaler restarts
    while (cyc < s0 + 1999) @(negedge clk);
    do_set(22'h123456);
    s2 = cyc;
    chk("set_tick_time", {10'd0, time_bcd}, 32'h123456);
    while (cyc < s2 + 999) @(negedge clk);
    chk("set_tick_hold", {10'd0, time_bcd}, 32'h123456);
    @(negedge clk);
    chk("set_tick_next", {10'd0, time_bcd}, 32'h123457);
    chk("frame3_data", {8'd0, rx_q[3]}, 32'h123456);
    $display("step set+tick: time=%06h frame=%06h", time_bcd, rx_q[3]);

    // Three sets during one frame collapse into one further frame
    wait_busy(1'b1, 5, "multi_frame_start");
    do_set(22'h010203);
    repeat (5) @(negedge clk);
    do_set(22'h040506);
    repeat (5) @(negedge clk);
    do_set(22'h070809);
    chk("multi_still_busy", {31'd0, busy}, 32'd1);
    chk("multi_time", {10'd0, time_bcd}, 32'h070809);
    wait_busy(1'b0, 120, "multi_frame_end");
    @(negedge clk);
    chk("collapse_restart", {31'd0, busy}, 32'd1);
    wait_busy(1'b0, 120, "collapse_end");
    hits = 0;
    repeat (150) begin
      @(negedge clk);
      if (busy === 1'b1) hits++;
    end
    chk("collapse_no_more", hits, 0);
    chk("collapse_count", rx_q.size(), 6);
    chk("frame4_data", {8'd0, rx_q[4]}, 32'h123457);
    chk("frame5_data", {8'd0, rx_q[5]}, 32'h070809);
    $display("step collapse: frames=%0d last=%06h", rx_q.size(), rx_q[5]);

    // Reset during a data BIT_HI phase
    do_set(22'h012345);
    n = 0;
    while (!(wclk === 1'b1 && lnk_reset === 1'b0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_bit_hi", {31'd0, (wclk === 1'b1 && lnk_reset === 1'b0)}, 32'd1);
    sz = rx_q.size();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_time", {10'd0, time_bcd}, {10'd0, RST_T});
    chk("midrst_outs", {27'd0, wclk, din, lnk_reset, busy, set_err}, 32'd0);
    chk("midrst_no_rx", rx_q.size(), sz);
    reset = 1'b0;
    wait_busy(1'b1, 5, "post_rst_start");
    wait_busy(1'b0, 120, "post_rst_end");
    chk("post_rst_count", rx_q.size(), sz + 1);
    chk("post_rst_data", {8'd0, rx_q[sz]}, {10'd0, RST_T});
    chk("total_reloads", rx_reloads, 8);
    chk("no_extra_rises", rx_extra, 0);
    $display("step midreset: frames=%0d last=%06h reloads=%0d extra=%0d",
             rx_q.size(), rx_q[sz], rx_reloads, rx_extra);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
